// File: rtl/zigbee_cordic_pkg.sv
// Shared phase-path types for the O-QPSK receiver back end.
package zigbee_cordic_pkg;

  localparam int W_SIZE_DEF = 8;
  localparam int SPC_DEF    = 4;

  typedef logic signed [W_SIZE_DEF-1:0] phase_t;

  typedef enum logic {
    UNPRIMED = 1'b0,
    RUN      = 1'b1
  } state_t;

endpackage

// File: rtl/zigbee_phase_diff_chip.sv
// Wrapped phase difference between consecutive valid samples, integrated over SPC diffs into a chip decision.
// Latency 1 cycle from validIn to dphaseValid/chipValid; no backpressure, every valid sample is consumed.
module zigbee_phase_diff_chip
  import zigbee_cordic_pkg::*;
#(
  parameter int W_SIZE   = W_SIZE_DEF,
  parameter int SPC      = SPC_DEF,
  parameter int ACC_SIZE = W_SIZE + $clog2(SPC)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [W_SIZE-1:0]   win,
  input  logic                       validIn,
  input  logic                       syncIn,
  output logic signed [W_SIZE-1:0]   dphaseOut,
  output logic                       dphaseValid,
  output logic signed [ACC_SIZE-1:0] accOut,
  output logic                       chipOut,
  output logic                       chipValid
);

  localparam int CNT_W = $clog2(SPC);
  localparam int EXT_W = ACC_SIZE - W_SIZE;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPC - 1);

  state_t                     state, state_nx;
  logic signed [W_SIZE-1:0]   prev_phase, prev_phase_nx;
  logic signed [ACC_SIZE-1:0] acc, acc_nx;
  logic [CNT_W-1:0]           cnt, cnt_nx;

  logic signed [W_SIZE-1:0]   dphase_nx;
  logic                       dphase_vld_nx;
  logic signed [ACC_SIZE-1:0] acc_out_nx;
  logic                       chip_nx;
  logic                       chip_vld_nx;

  // Modular subtraction: a wrap from +max to -max falls out naturally.
  logic signed [W_SIZE-1:0]   d;
  logic signed [ACC_SIZE-1:0] d_ext;
  logic signed [ACC_SIZE-1:0] acc_sum;

  assign d       = win - prev_phase;
  assign d_ext   = {{EXT_W{d[W_SIZE-1]}}, d};
  assign acc_sum = acc + d_ext;

  always_comb begin
    state_nx      = state;
    prev_phase_nx = prev_phase;
    acc_nx        = acc;
    cnt_nx        = cnt;
    dphase_nx     = dphaseOut;
    dphase_vld_nx = 1'b0;
    acc_out_nx    = accOut;
    chip_nx       = chipOut;
    chip_vld_nx   = 1'b0;

    if (syncIn) begin
      acc_nx = '0;
      cnt_nx = '0;
    end

    if (validIn) begin
      prev_phase_nx = win;
      case (state)
        UNPRIMED: state_nx = RUN;
        RUN: begin
          dphase_nx     = d;
          dphase_vld_nx = 1'b1;
          if (syncIn) begin
            // The coincident diff opens the new chip rather than closing the old one.
            acc_nx = d_ext;
            cnt_nx = CNT_W'(1);
          end else if (cnt == CNT_LAST) begin
            acc_out_nx  = acc_sum;
            chip_nx     = !acc_sum[ACC_SIZE-1] && (acc_sum != '0);
            chip_vld_nx = 1'b1;
            acc_nx      = '0;
            cnt_nx      = '0;
          end else begin
            acc_nx = acc_sum;
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        default: state_nx = UNPRIMED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= UNPRIMED;
      prev_phase  <= '0;
      acc         <= '0;
      cnt         <= '0;
      dphaseOut   <= '0;
      dphaseValid <= 1'b0;
      accOut      <= '0;
      chipOut     <= 1'b0;
      chipValid   <= 1'b0;
    end else begin
      state       <= state_nx;
      prev_phase  <= prev_phase_nx;
      acc         <= acc_nx;
      cnt         <= cnt_nx;
      dphaseOut   <= dphase_nx;
      dphaseValid <= dphase_vld_nx;
      accOut      <= acc_out_nx;
      chipOut     <= chip_nx;
      chipValid   <= chip_vld_nx;
    end
  end

endmodule

// File: tb/tb_zigbee_phase_diff_chip.sv
// Vector-table bench for zigbee_phase_diff_chip (W_SIZE=8, SPC=4).
module tb_zigbee_phase_diff_chip;

  logic              clk;
  logic              rst_n;
  logic signed [7:0] win;
  logic              validIn;
  logic              syncIn;
  logic signed [7:0] dphaseOut;
  logic              dphaseValid;
  logic signed [9:0] accOut;
  logic              chipOut;
  logic              chipValid;

  int total = 0;
  int bad   = 0;

  zigbee_phase_diff_chip #(.W_SIZE(8), .SPC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .win        (win),
    .validIn    (validIn),
    .syncIn     (syncIn),
    .dphaseOut  (dphaseOut),
    .dphaseValid(dphaseValid),
    .accOut     (accOut),
    .chipOut    (chipOut),
    .chipValid  (chipValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit r;     // apply reset instead of a sample
    bit v;
    bit s;
    int w;
    bit edv;
    int ed;
    bit ecv;
    int eacc;
    bit echip;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t mk(bit r, bit v, bit s, int w, bit edv, int ed,
                              bit ecv, int eacc, bit echip);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.w = w;
    t.edv = edv; t.ed = ed; t.ecv = ecv; t.eacc = eacc; t.echip = echip;
    return t;
  endfunction

  function automatic vec_t smp(int w, bit edv, int ed);
    return mk(0, 1, 0, w, edv, ed, 0, 0, 0);
  endfunction

  function automatic vec_t chip(int w, int ed, int eacc, bit echip);
    return mk(0, 1, 0, w, 1, ed, 1, eacc, echip);
  endfunction

  function automatic vec_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t rst();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(string name, int idx, logic signed [31:0] act, logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @vec%0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_all_zero(string tag, int idx);
    chk({tag, ".dphaseOut"},   idx, dphaseOut,   0);
    chk({tag, ".dphaseValid"}, idx, dphaseValid, 0);
    chk({tag, ".accOut"},      idx, accOut,      0);
    chk({tag, ".chipOut"},     idx, chipOut,     0);
    chk({tag, ".chipValid"},   idx, chipValid,   0);
  endtask

  task automatic apply(vec_t t, int idx);
    vec_t e;
    @(negedge clk);
    if (t.r) begin
      validIn = 1'b0; syncIn = 1'b0; win = '0;
      rst_n = 1'b0;
      #1;
      chk_all_zero("reset", idx);
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      validIn = t.v; syncIn = t.s; win = 8'(t.w);
      exp_q.push_back(t);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("dphaseValid", idx, dphaseValid, e.edv);
      if (e.edv) chk("dphaseOut", idx, dphaseOut, e.ed);
      chk("chipValid", idx, chipValid, e.ecv);
      if (e.ecv) begin
        chk("accOut", idx, accOut, e.eacc);
        chk("chipOut", idx, chipOut, e.echip);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; validIn = 1'b0; syncIn = 1'b0; win = '0;

    // Ramp up, continuous valid.
    tbl.push_back(rst());
    tbl.push_back(smp(0, 0, 0));
    tbl.push_back(smp(16, 1, 16));
    tbl.push_back(smp(32, 1, 16));
    tbl.push_back(smp(48, 1, 16));
    tbl.push_back(chip(64, 16, 64, 1));
    tbl.push_back(idle());

    // Ramp down, then a +127/-128 style wrap.
    tbl.push_back(rst());
    tbl.push_back(smp(8, 0, 0));
    tbl.push_back(smp(-8, 1, -16));
    tbl.push_back(smp(-24, 1, -16));
    tbl.push_back(smp(-40, 1, -16));
    tbl.push_back(chip(-56, -16, -64, 0));
    tbl.push_back(smp(120, 1, -80));
    tbl.push_back(smp(-120, 1, 16));

    // Gapped valid: one sample every third cycle.
    tbl.push_back(rst());
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      tbl.push_back(smp(0, 0, 0));
      else if (i == 4) tbl.push_back(chip(64, 16, 64, 1));
      else             tbl.push_back(smp(16 * i, 1, 16));
      tbl.push_back(idle());
      tbl.push_back(idle());
    end

    // Standalone sync aborts a partial chip.
    tbl.push_back(rst());
    tbl.push_back(smp(0, 0, 0));
    tbl.push_back(smp(16, 1, 16));
    tbl.push_back(smp(32, 1, 16));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(smp(16, 1, -16));
    tbl.push_back(smp(0, 1, -16));
    tbl.push_back(smp(-16, 1, -16));
    tbl.push_back(chip(-32, -16, -64, 0));

    // Sync coincident with a valid diff starts the next chip with it.
    tbl.push_back(rst());
    tbl.push_back(smp(0, 0, 0));
    tbl.push_back(smp(10, 1, 10));
    tbl.push_back(smp(20, 1, 10));
    tbl.push_back(mk(0, 1, 1, 30, 1, 10, 0, 0, 0));
    tbl.push_back(smp(40, 1, 10));
    tbl.push_back(smp(50, 1, 10));
    tbl.push_back(chip(60, 10, 40, 1));

    // Half-turn diffs taken as -128, and a zero sum giving chip 0.
    tbl.push_back(rst());
    tbl.push_back(smp(0, 0, 0));
    tbl.push_back(smp(-128, 1, -128));
    tbl.push_back(smp(0, 1, -128));
    tbl.push_back(smp(-128, 1, -128));
    tbl.push_back(chip(0, -128, -512, 0));
    tbl.push_back(smp(16, 1, 16));
    tbl.push_back(smp(0, 1, -16));
    tbl.push_back(smp(16, 1, 16));
    tbl.push_back(chip(0, -16, 0, 0));

    // Mid-chip reset preamble: two diffs accepted before the hand sequence.
    tbl.push_back(rst());
    tbl.push_back(smp(0, 0, 0));
    tbl.push_back(smp(16, 1, 16));
    tbl.push_back(smp(32, 1, 16));

    foreach (tbl[i]) apply(tbl[i], i);

    // Asynchronous reset taken between edges must clear outputs at once.
    @(posedge clk);
    #3;
    validIn = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst", -1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    tbl.delete();
    tbl.push_back(smp(100, 0, 0));
    tbl.push_back(smp(110, 1, 10));
    tbl.push_back(smp(120, 1, 10));
    tbl.push_back(smp(-126, 1, 10));
    tbl.push_back(chip(-116, 10, 40, 1));
    tbl.push_back(idle());
    foreach (tbl[i]) apply(tbl[i], 1000 + i);

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: got %0d leftover entries, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zigbee_phase_diff_chip.md
Name: zigbee_phase_diff_chip

Overview:
- Sits directly downstream of the last CORDIC rotation stage of the O-QPSK receiver.
- Consumes the per-sample phase word and its valid strobe.
- Computes the wrapped phase difference between consecutive valid samples, then integrates SPC differences per chip period.
- Outputs a hard chip decision (rotation sense) with a valid strobe, for the downstream despreader.

Parameters:
- W_SIZE, 8, phase word width. Full turn = 2^W_SIZE LSB; signed two's complement.
- SPC, 4, valid samples per chip; legal range 2..16.
- ACC_SIZE, W_SIZE+$clog2(SPC), accumulator width; guarantees no overflow over SPC differences.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- win  in  W_SIZE  signed phase from the CORDIC stage.
- validIn  in  1  win valid this cycle; may be high every cycle or gapped.
- syncIn  in  1  chip-boundary realign; single-cycle pulse.
- dphaseOut  out  W_SIZE  signed wrapped phase difference, registered.
- dphaseValid  out  1  dphaseOut valid, one-cycle pulse.
- accOut  out  ACC_SIZE  signed accumulated difference of the completed chip.
- chipOut  out  1  chip decision.
- chipValid  out  1  chipOut/accOut valid, one-cycle pulse.

Interface: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset values: all outputs 0. Internal registers prevPhase=0, acc=0, cnt=0, state=UNPRIMED.

State machine:
- UNPRIMED: on validIn, store win into prevPhase and go to RUN. No dphaseValid is issued.
- RUN: on each validIn:
  - d = win - prevPhase, computed in W_SIZE bits (modulo 2^W_SIZE, natural wrap).
  - prevPhase <= win.
  - dphaseOut <= d and dphaseValid <= 1 on the next edge (latency 1 cycle).
  - acc <= acc + sign-extended d; cnt <= cnt+1.
- Chip completion: when a diff is accepted with cnt==SPC-1, on the same edge:
  - accOut <= acc + d.
  - chipOut <= 1 if (acc+d) > 0, else 0 (zero and negative both give 0).
  - chipValid <= 1.
  - acc <= 0, cnt <= 0.
  - chipValid therefore rises 1 cycle after the SPC-th diff's validIn.
- No validIn: all state is held; valid outputs are 0.

syncIn:
- Clears acc and cnt; prevPhase and state are kept.
- Sync with validIn in the same cycle: the diff is still computed and output on dphaseOut. It becomes the first term of the new chip (acc <= d, cnt <= 1), and no chipValid is issued that cycle.
- Sync in UNPRIMED: no effect beyond the clears.

Wrap and sign rules:
- Wrap handling is purely modular: +127 to -128 gives d=+1 for W_SIZE=8. No explicit unwrap logic is needed.
- Difference of exactly half a turn: d = -2^(W_SIZE-1), taken as is.

Reset mid-operation: asserting rst_n low clears everything immediately, asynchronously. After release, the block returns to UNPRIMED and the first valid sample only primes prevPhase.

Decomposition:
- Shared package zigbee_cordic_pkg holds the phase type of width W_SIZE, the state enum {UNPRIMED, RUN}, and the localparam for the default SPC.
- The block is a single module. The modular subtract-and-sign-extend is small and stays inline; no sub-module.

Test Plan (W_SIZE=8, SPC=4):
- Ramp up: validIn every cycle, win=0,16,32,48,64 → no dphaseValid on the first sample; then dphaseOut=16 ×4, accOut=64, chipOut=1; chipValid exactly 1 cycle after the 5th sample.
- Ramp down with wrap: win=8,-8,-24,-40,-56 → dphase=-16 ×4, accOut=-64, chipOut=0. Then win=120,-120 → dphaseOut=+16 (wrap).
- Gapped valid: same ramp as the first scenario with validIn high every 3rd cycle → identical dphaseOut/accOut/chipOut sequence; outputs pulse only after valid cycles.
- syncIn after 2 diffs of +16, then diffs -16 ×4 → accOut=-64, chipOut=0; no chipValid for the aborted chip.
- syncIn coincident with validIn (d=+10), then 3 more diffs of +10 → chipValid with accOut=40 on the 3rd following diff.
- rst_n low for 1 cycle mid-chip (cnt=2) → all outputs 0 immediately. Next valid sample produces no dphaseValid; counting restarts from 0.
